// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage register: occupancy states and level encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int LEVEL_W = 2;
  typedef logic [LEVEL_W-1:0] pipe_level_t;

  // State encoding doubles as the occupancy count.
  function automatic pipe_level_t state_level(input pipe_state_e s);
    return pipe_level_t'(s);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register; ctrl is zeroed whenever the slot empties,
// data keeps its last value except on reset.
module pipe_slot #(
  parameter int              DW       = 32,
  parameter int              CW       = 4,
  parameter logic [DW-1:0]   RST_DATA = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [CW-1:0] i_ctrl,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [CW-1:0] o_ctrl,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [CW-1:0] r_ctrl;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= RST_DATA;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush and control-field gating for bubbles.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            CW       = 4,
  parameter logic [DW-1:0] RST_DATA = '0,
  parameter bit            SKID     = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FLUSH,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctrl,
  output logic [DW-1:0] out_data,
  output logic [1:0]    level
);

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_main_load;
  logic          w_main_clear;
  logic [CW-1:0] w_main_ctrl;
  logic [DW-1:0] w_main_data;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  pipe_slot #(.DW(DW), .CW(CW), .RST_DATA(RST_DATA)) u_main (
    .clk     (CLK),
    .rst     (RESET),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl),
    .i_data  (w_main_data),
    .o_valid (out_valid),
    .o_ctrl  (out_ctrl),
    .o_data  (out_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_state_e   r_state;
      pipe_state_e   w_state_next;
      logic          r_in_ready;
      logic          w_skid_load;
      logic          w_skid_clear;
      logic          w_skid_valid;
      logic [CW-1:0] w_skid_ctrl;
      logic [DW-1:0] w_skid_data;

      pipe_slot #(.DW(DW), .CW(CW), .RST_DATA('0)) u_skid (
        .clk     (CLK),
        .rst     (RESET),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );

      // Main refills from the skid slot only when draining out of FULL.
      assign w_main_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
      assign w_main_data = w_skid_valid ? w_skid_data : in_data;

      always_comb begin
        w_state_next = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (FLUSH) begin
          w_state_next = EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end else begin
          case (r_state)
            EMPTY: begin
              if (w_in_xfer) begin
                w_state_next = ONE;
                w_main_load  = 1'b1;
              end
            end
            ONE: begin
              if (w_in_xfer && w_out_xfer) begin
                w_main_load = 1'b1;
              end else if (w_in_xfer) begin
                w_state_next = FULL;
                w_skid_load  = 1'b1;
              end else if (w_out_xfer) begin
                w_state_next = EMPTY;
                w_main_clear = 1'b1;
              end
            end
            FULL: begin
              if (w_out_xfer) begin
                w_state_next = ONE;
                w_main_load  = 1'b1;
                w_skid_clear = 1'b1;
              end
            end
            default: w_state_next = EMPTY;
          endcase
        end
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_next;
          r_in_ready <= (w_state_next != FULL);
        end
      end

      assign in_ready = r_in_ready;
      assign level    = state_level(r_state);
    end else begin : g_single
      pipe_state_e r_state;

      // Downstream readiness passes straight through so a draining entry can be replaced.
      assign in_ready     = out_ready | ~out_valid;
      assign w_main_ctrl  = in_ctrl;
      assign w_main_data  = in_data;
      assign w_main_load  = w_in_xfer & ~FLUSH;
      assign w_main_clear = FLUSH | (w_out_xfer & ~w_in_xfer);

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          r_state <= EMPTY;
        end else if (FLUSH) begin
          r_state <= EMPTY;
        end else if (w_in_xfer) begin
          r_state <= ONE;
        end else if (w_out_xfer) begin
          r_state <= EMPTY;
        end
      end

      assign level = state_level(r_state);
    end
  endgenerate

endmodule
